// File: rtl/mask_stim_gen_if.sv
// ---------------------------------------------------------------------------
// mask_stim_gen_if
// Stream bundle between the stimulus generator and the 16-bit masking stage.
//   a_out     data word handed to the masking stage
//   mask_out  mask word handed to the masking stage
//   valid     a_out/mask_out hold a pair
//   ready     downstream accepts; a pair moves when valid & ready at clk edge
// Modports: master (generator side), slave (masking-stage side).
// ---------------------------------------------------------------------------
interface mask_stim_gen_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a_out;
  logic [WIDTH-1:0] mask_out;
  logic             valid;
  logic             ready;

  modport master (output a_out, output mask_out, output valid, input ready);
  modport slave  (input a_out, input mask_out, input valid, output ready);
endinterface

// File: rtl/mask_stim_gen.sv
// ---------------------------------------------------------------------------
// mask_stim_gen
// Hardware stimulus source for the masking stage (b = a & mask). Emits
// NUM_VECTORS biased pseudo-random (a, mask) pairs over a valid/ready stream.
// Each bit is 1 when a 4-bit nibble of a 32-bit Galois LFSR is >= THRESH.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous reset, active high
//   start      in   1      begins a run when sampled in IDLE or DONE
//   stream     master      a_out / mask_out / valid out, ready in
//   busy       out  1      high while generating or presenting a pair
//   done       out  1      high once the run has finished
//   vec_count  out  32     pairs transferred in the current run
//   sig_out    out  WIDTH  rotate-xor signature of a_out & mask_out
//                          (present only with MASK_STIM_SIG_EN defined)
//
// Optional feature macro: MASK_STIM_SIG_EN (adds sig_out and its logic).
// ---------------------------------------------------------------------------
module mask_stim_gen #(
  parameter int          WIDTH       = 16,
  parameter logic [31:0] NUM_VECTORS = 32'd20000,
  parameter logic [31:0] SEED        = 32'hACE11234,
  parameter int          THRESH      = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  mask_stim_gen_if.master      stream,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          vec_count
`ifdef MASK_STIM_SIG_EN
  ,
  output logic [WIDTH-1:0]     sig_out
`endif
);

  // A zero seed would lock the LFSR at zero forever.
  localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
  localparam logic [31:0] POLY     = 32'h80200003;
  // Five bits so THRESH = 16 (never true) can be expressed.
  localparam logic [4:0]  THRESH_5 = 5'(THRESH);
  localparam int          CNT_W    = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GEN,
    S_VALID,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [31:0]      lfsr;
  logic [31:0]      lfsr_next;
  logic [CNT_W-1:0] bit_cnt;
  logic [WIDTH-1:0] shadow_a;
  logic [WIDTH-1:0] shadow_m;
  logic [WIDTH-1:0] shadow_a_next;
  logic [WIDTH-1:0] shadow_m_next;
  logic             a_bit;
  logic             m_bit;
  logic             last_bit;
  logic             xfer;
  logic             start_accept;
  logic [31:0]      count_inc;
  logic             last_vec;

  assign last_bit     = (bit_cnt == LAST_BIT);
  assign xfer         = (state == S_VALID) && stream.ready;
  assign start_accept = start && ((state == S_IDLE) || (state == S_DONE));
  assign count_inc    = vec_count + 32'd1;
  assign last_vec     = (count_inc == NUM_VECTORS);

  // Right-shifting Galois step; the feedback taps are xored in when the
  // bit shifted out is 1.
  assign lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? POLY : 32'h0);

  // Bits are decided from the pre-advance LFSR value and shifted in from
  // the top, so the bit of GEN cycle 0 ends up in bit 0 after WIDTH cycles.
  assign a_bit         = ({1'b0, lfsr[3:0]} >= THRESH_5);
  assign m_bit         = ({1'b0, lfsr[7:4]} >= THRESH_5);
  assign shadow_a_next = {a_bit, shadow_a[WIDTH-1:1]};
  assign shadow_m_next = {m_bit, shadow_m[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next   = state;
    stream.valid = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_GEN;
      end
      S_GEN: begin
        busy = 1'b1;
        if (last_bit) state_next = S_VALID;
      end
      S_VALID: begin
        busy         = 1'b1;
        stream.valid = 1'b1;
        if (stream.ready) state_next = last_vec ? S_DONE : S_GEN;
      end
      S_DONE: begin
        done = 1'b1;
        if (start) state_next = S_GEN;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: the LFSR only moves in GEN, and the visible pair is loaded
  // just once per vector so it stays frozen while valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr            <= SEED_EFF;
      bit_cnt         <= '0;
      shadow_a        <= '0;
      shadow_m        <= '0;
      stream.a_out    <= '0;
      stream.mask_out <= '0;
      vec_count       <= 32'd0;
    end else begin
      if (state == S_GEN) begin
        lfsr     <= lfsr_next;
        shadow_a <= shadow_a_next;
        shadow_m <= shadow_m_next;
        if (last_bit) begin
          bit_cnt         <= '0;
          stream.a_out    <= shadow_a_next;
          stream.mask_out <= shadow_m_next;
        end else begin
          bit_cnt <= bit_cnt + 1'b1;
        end
      end
      if (start_accept) begin
        vec_count <= 32'd0;
      end else if (xfer) begin
        vec_count <= count_inc;
      end
    end
  end

`ifdef MASK_STIM_SIG_EN
  // Rotate-left then fold in the masked word of every transferred pair.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_out <= '0;
    end else if (start_accept) begin
      sig_out <= '0;
    end else if (xfer) begin
      sig_out <= {sig_out[WIDTH-2:0], sig_out[WIDTH-1]} ^
                 (stream.a_out & stream.mask_out);
    end
  end
`endif

endmodule

// File: tb/tb_mask_stim_gen.sv
// ---------------------------------------------------------------------------
// tb_mask_stim_gen
// Directed bench for mask_stim_gen. Four instances share one clock and reset:
//   main  NUM_VECTORS=3, default seed/threshold (run, stall, async reset)
//   t0    THRESH=0,  NUM_VECTORS=2 (all-ones words, signature when enabled)
//   t16   THRESH=16, NUM_VECTORS=2 (all-zero words)
//   big   SEED=0 (replaced by 1), NUM_VECTORS=2000 (stream and density)
// Expected pairs come from a small LFSR model kept by the bench.
// ---------------------------------------------------------------------------
module tb_mask_stim_gen;

  logic        clk;
  logic        rst;
  logic        start_main, start_t0, start_t16, start_big;
  logic        busy_main, busy_t0, busy_t16, busy_big;
  logic        done_main, done_t0, done_t16, done_big;
  logic [31:0] vc_main, vc_t0, vc_t16, vc_big;
`ifdef MASK_STIM_SIG_EN
  logic [15:0] sig_main, sig_t0, sig_t16, sig_big;
`endif

  int          checks;
  int          passes;
  int          cyc;

  mask_stim_gen_if #(.WIDTH(16)) ms ();
  mask_stim_gen_if #(.WIDTH(16)) s0 ();
  mask_stim_gen_if #(.WIDTH(16)) s16 ();
  mask_stim_gen_if #(.WIDTH(16)) sb ();

  mask_stim_gen #(.WIDTH(16), .NUM_VECTORS(32'd3)) dut_main (
    .clk(clk), .rst(rst), .start(start_main), .stream(ms),
    .busy(busy_main), .done(done_main), .vec_count(vc_main)
`ifdef MASK_STIM_SIG_EN
    , .sig_out(sig_main)
`endif
  );

  mask_stim_gen #(.WIDTH(16), .NUM_VECTORS(32'd2), .THRESH(0)) dut_t0 (
    .clk(clk), .rst(rst), .start(start_t0), .stream(s0),
    .busy(busy_t0), .done(done_t0), .vec_count(vc_t0)
`ifdef MASK_STIM_SIG_EN
    , .sig_out(sig_t0)
`endif
  );

  mask_stim_gen #(.WIDTH(16), .NUM_VECTORS(32'd2), .THRESH(16)) dut_t16 (
    .clk(clk), .rst(rst), .start(start_t16), .stream(s16),
    .busy(busy_t16), .done(done_t16), .vec_count(vc_t16)
`ifdef MASK_STIM_SIG_EN
    , .sig_out(sig_t16)
`endif
  );

  mask_stim_gen #(.WIDTH(16), .NUM_VECTORS(32'd2000), .SEED(32'h0)) dut_big (
    .clk(clk), .rst(rst), .start(start_big), .stream(sb),
    .busy(busy_big), .done(done_big), .vec_count(vc_big)
`ifdef MASK_STIM_SIG_EN
    , .sig_out(sig_big)
`endif
  );

  // Free-running clock and a cycle stamp used to measure transfer spacing.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] lfsrStep(input logic [31:0] s);
    logic [31:0] r;
    r = s >> 1;
    if (s[0]) r = r ^ 32'h80200003;
    return r;
  endfunction

  // One pair from the model: 16 LFSR steps, bit k from the value before step k.
  task automatic modelPair(input int thresh, inout logic [31:0] st,
                           output logic [15:0] ea, output logic [15:0] em);
    for (int k = 0; k < 16; k++) begin
      ea[k] = (int'(st[3:0]) >= thresh);
      em[k] = (int'(st[7:4]) >= thresh);
      st    = lfsrStep(st);
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) passes++;
    else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
  endtask

  // One-cycle start pulse on the selected instance(s), bit per instance.
  task automatic applyStimulus(input logic [3:0] sel);
    start_main = sel[0];
    start_t0   = sel[1];
    start_t16  = sel[2];
    start_big  = sel[3];
    @(posedge clk); #1;
    start_main = 1'b0;
    start_t0   = 1'b0;
    start_t16  = 1'b0;
    start_big  = 1'b0;
  endtask

  logic [31:0] mlfsr_main, mlfsr_big;
  logic [15:0] ea, em, hold_a, hold_m;
  logic [31:0] hold_vc;
  int          n, guard, changed, mism, ones;
  int          xfer_cyc [3];

  initial begin
    checks = 0;
    passes = 0;
    rst = 1'b1;
    start_main = 1'b0; start_t0 = 1'b0; start_t16 = 1'b0; start_big = 1'b0;
    ms.ready = 1'b0; s0.ready = 1'b0; s16.ready = 1'b0; sb.ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset values
    checkOutput("rst_a", 32'(ms.a_out), 32'h0);
    checkOutput("rst_mask", 32'(ms.mask_out), 32'h0);
    checkOutput("rst_valid", 32'(ms.valid), 32'h0);
    checkOutput("rst_busy", 32'(busy_main), 32'h0);
    checkOutput("rst_done", 32'(done_main), 32'h0);
    checkOutput("rst_vc", vc_main, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Test 1: three transfers with ready held high
    $display("[TB] test 1: basic run of 3 pairs");
    mlfsr_main = 32'hACE11234;
    ms.ready = 1'b1;
    applyStimulus(4'b0001);
    n = 0;
    guard = 0;
    while (n < 3 && guard < 200) begin
      if (ms.valid) begin
        modelPair(10, mlfsr_main, ea, em);
        checkOutput("t1_a", 32'(ms.a_out), 32'(ea));
        checkOutput("t1_mask", 32'(ms.mask_out), 32'(em));
        xfer_cyc[n] = cyc;
        n++;
      end
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("t1_xfers", n, 3);
    checkOutput("t1_gap12", xfer_cyc[1] - xfer_cyc[0], 17);
    checkOutput("t1_gap23", xfer_cyc[2] - xfer_cyc[1], 17);
    checkOutput("t1_done", 32'(done_main), 32'h1);
    checkOutput("t1_vc", vc_main, 32'd3);
    checkOutput("t1_valid_low", 32'(ms.valid), 32'h0);
    checkOutput("t1_busy_low", 32'(busy_main), 32'h0);

    // Test 3: restart from DONE and stall with ready low
    $display("[TB] test 3: stall for 50 cycles");
    ms.ready = 1'b0;
    applyStimulus(4'b0001);
    checkOutput("t3_done_drop", 32'(done_main), 32'h0);
    checkOutput("t3_vc_clear", vc_main, 32'h0);
    guard = 0;
    while (!ms.valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("t3_valid_seen", 32'(ms.valid), 32'h1);
    modelPair(10, mlfsr_main, ea, em);
    checkOutput("t3_a_continues", 32'(ms.a_out), 32'(ea));
    checkOutput("t3_mask_continues", 32'(ms.mask_out), 32'(em));
    hold_a  = ms.a_out;
    hold_m  = ms.mask_out;
    hold_vc = vc_main;
    changed = 0;
    repeat (50) begin
      @(posedge clk); #1;
      if (ms.a_out !== hold_a || ms.mask_out !== hold_m ||
          vc_main !== hold_vc || ms.valid !== 1'b1) changed++;
    end
    checkOutput("t3_hold_changes", changed, 0);
    ms.ready = 1'b1;
    @(posedge clk); #1;
    ms.ready = 1'b0;
    checkOutput("t3_single_xfer_vc", vc_main, 32'd1);
    checkOutput("t3_valid_after", 32'(ms.valid), 32'h0);
    checkOutput("t3_busy_after", 32'(busy_main), 32'h1);

    // Test 4: asynchronous reset while generating the 2nd vector
    $display("[TB] test 4: async reset mid-run");
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("t4_a", 32'(ms.a_out), 32'h0);
    checkOutput("t4_mask", 32'(ms.mask_out), 32'h0);
    checkOutput("t4_vc", vc_main, 32'h0);
    checkOutput("t4_busy", 32'(busy_main), 32'h0);
    checkOutput("t4_valid", 32'(ms.valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    mlfsr_main = 32'hACE11234;
    ms.ready = 1'b1;
    applyStimulus(4'b0001);
    guard = 0;
    while (!ms.valid && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("t4_valid_seen", 32'(ms.valid), 32'h1);
    modelPair(10, mlfsr_main, ea, em);
    checkOutput("t4_first_a", 32'(ms.a_out), 32'(ea));
    checkOutput("t4_first_mask", 32'(ms.mask_out), 32'(em));
    guard = 0;
    while (!done_main && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("t4_run_done", 32'(done_main), 32'h1);

    // Test 2 (and signature): THRESH 0 and 16 run side by side
    $display("[TB] test 2: threshold extremes");
    s0.ready  = 1'b1;
    s16.ready = 1'b1;
    applyStimulus(4'b0110);
    n = 0;
    guard = 0;
    while (n < 2 && guard < 100) begin
      if (s0.valid) begin
        checkOutput("t2_th0_a", 32'(s0.a_out), 32'h0000FFFF);
        checkOutput("t2_th0_mask", 32'(s0.mask_out), 32'h0000FFFF);
        checkOutput("t2_th16_valid", 32'(s16.valid), 32'h1);
        checkOutput("t2_th16_a", 32'(s16.a_out), 32'h0);
        checkOutput("t2_th16_mask", 32'(s16.mask_out), 32'h0);
        n++;
        @(posedge clk); #1;
`ifdef MASK_STIM_SIG_EN
        checkOutput("t6_sig", 32'(sig_t0), (n == 1) ? 32'h0000FFFF : 32'h0);
`endif
      end else begin
        @(posedge clk); #1;
      end
      guard++;
    end
    checkOutput("t2_xfers", n, 2);
    checkOutput("t2_th0_done", 32'(done_t0), 32'h1);
    checkOutput("t2_th16_vc", vc_t16, 32'd2);
`ifdef MASK_STIM_SIG_EN
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t6_sig_held", 32'(sig_t0), 32'h0);
`endif

    // Test 5: long stream against the model, zero seed replaced by 1
    $display("[TB] test 5: 2000-pair stream and density");
    mlfsr_big = 32'h1;
    sb.ready = 1'b1;
    applyStimulus(4'b1000);
    n = 0;
    guard = 0;
    mism = 0;
    ones = 0;
    while (n < 2000 && guard < 40000) begin
      if (sb.valid) begin
        modelPair(10, mlfsr_big, ea, em);
        if (sb.a_out !== ea || sb.mask_out !== em) mism++;
        ones += $countones(sb.a_out) + $countones(sb.mask_out);
        n++;
      end
      @(posedge clk); #1;
      guard++;
    end
    checkOutput("t5_xfers", n, 2000);
    checkOutput("t5_stream_mismatches", mism, 0);
    checkOutput("t5_density_in_range", 32'(ones >= 23360 && ones <= 24640), 32'h1);
    checkOutput("t5_done", 32'(done_big), 32'h1);
    checkOutput("t5_vc", vc_big, 32'd2000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
